// File: rtl/framer_pkg.sv
// Shared types and helpers for the I2S receive-side sample framer.
package framer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } framer_state_e;

  localparam int unsigned DEFAULT_DATA_WIDTH = 24;

  // FIFO entries carry the sample plus its tlast bit.
  function automatic int unsigned fifo_entry_width(input int unsigned data_width);
    return data_width + 1;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO with a registered output stage; the output register counts
// toward the 2^AW capacity, and a read frees a slot for a same-cycle write.
module sample_fifo #(
  parameter int unsigned WIDTH = 25,
  parameter int unsigned AW    = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_ready,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_rd_valid,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_LVL = {1'b1, {AW{1'b0}}};

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_mem_cnt;
  logic             r_valid;
  logic [WIDTH-1:0] r_dout;

  logic        w_rd;
  logic        w_wr;
  logic        w_pop;
  logic [AW:0] w_total;

  assign w_rd    = r_valid & i_rd_ready;
  assign w_total = r_mem_cnt + {{AW{1'b0}}, r_valid};
  assign o_full  = (w_total == FULL_LVL);
  assign o_empty = (w_total == '0);
  assign w_wr    = i_wr_en & (~o_full | w_rd);
  // Refill the output register only from the array, so a write never bypasses.
  assign w_pop   = (r_mem_cnt != '0) & (~r_valid | w_rd);

  always_ff @(posedge i_clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_mem_cnt <= '0;
      r_valid   <= 1'b0;
      r_dout    <= '0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_wr, w_pop})
        2'b10:   r_mem_cnt <= r_mem_cnt + {{AW{1'b0}}, 1'b1};
        2'b01:   r_mem_cnt <= r_mem_cnt - {{AW{1'b0}}, 1'b1};
        default: r_mem_cnt <= r_mem_cnt;
      endcase
      if (w_pop) begin
        r_dout  <= r_mem[r_rptr];
        r_valid <= 1'b1;
      end else if (w_rd) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_rd_data  = r_dout;
  assign o_rd_valid = r_valid;

endmodule

// File: rtl/i2s_sample_framer.sv
// Captures one mic word per LRCLK period into a FIFO and streams it out in
// fixed-length frames. Optional drop counter: FRAMER_OVF_CNT_EN.
module i2s_sample_framer
  import framer_pkg::*;
#(
  parameter int unsigned C_DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned FRAME_LEN    = 256,
  parameter int unsigned FIFO_AW      = 4
) (
  input  logic                           CLK_12,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           LRCLK_I,
  input  logic signed [C_DATA_WIDTH-1:0] mic_sample,
  output logic signed [C_DATA_WIDTH-1:0] m_tdata,
  output logic                           m_tvalid,
  input  logic                           m_tready,
  output logic                           m_tlast,
  output logic                           busy,
  output logic                           ovf
`ifdef FRAMER_OVF_CNT_EN
  ,
  output logic [15:0]                    ovf_count
`endif
);

  localparam int unsigned EW = fifo_entry_width(C_DATA_WIDTH);
  localparam int unsigned CW = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

  framer_state_e r_state;
  framer_state_e w_state_nxt;
  logic          r_lrclk_q;
  logic [CW-1:0] r_frame_cnt;
  logic          r_ovf;

  logic          w_event;
  logic          w_cap;
  logic          w_room;
  logic          w_wr;
  logic          w_drop;
  logic          w_last;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic [EW-1:0] w_rd_data;

  assign w_event = LRCLK_I & ~r_lrclk_q;
  assign w_cap   = w_event & (enable | (r_state != IDLE));
  assign w_room  = w_fifo_empty | ~w_fifo_full | (m_tvalid & m_tready);
  assign w_wr    = w_cap & w_room;
  assign w_drop  = w_cap & ~w_room;
  assign w_last  = (r_frame_cnt == LAST_IDX);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_wr) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        // A dropped sample on a frame boundary leaves no open frame to finish.
        if (w_event & ~enable) begin
          if (w_wr ? w_last : (r_frame_cnt == '0)) begin
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (enable) begin
          w_state_nxt = RUN;
        end else if (w_wr & w_last) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK_12 or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_lrclk_q   <= 1'b1;
      r_frame_cnt <= '0;
      r_ovf       <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_lrclk_q <= LRCLK_I;
      if (w_wr) begin
        r_frame_cnt <= w_last ? '0 : r_frame_cnt + CW'(1);
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
    end
  end

`ifdef FRAMER_OVF_CNT_EN
  logic [15:0] r_ovf_count;

  always_ff @(posedge CLK_12 or posedge reset) begin
    if (reset) begin
      r_ovf_count <= '0;
    end else if (w_drop && (r_ovf_count != 16'hFFFF)) begin
      r_ovf_count <= r_ovf_count + 16'd1;
    end
  end

  assign ovf_count = r_ovf_count;
`endif

  sample_fifo #(
    .WIDTH (EW),
    .AW    (FIFO_AW)
  ) u_fifo (
    .i_clk      (CLK_12),
    .i_rst      (reset),
    .i_wr_en    (w_wr),
    .i_wr_data  ({w_last, mic_sample}),
    .i_rd_ready (m_tready),
    .o_rd_data  (w_rd_data),
    .o_rd_valid (m_tvalid),
    .o_full     (w_fifo_full),
    .o_empty    (w_fifo_empty)
  );

  assign m_tdata = w_rd_data[C_DATA_WIDTH-1:0];
  assign m_tlast = w_rd_data[C_DATA_WIDTH];
  assign busy    = (r_state != IDLE);
  assign ovf     = r_ovf;

endmodule

// File: tb/tb_i2s_sample_framer.sv
// Self-checking bench for i2s_sample_framer (FRAME_LEN=4, FIFO depth 4).
module tb_i2s_sample_framer;

  localparam int unsigned W     = 24;
  localparam int unsigned FL    = 4;
  localparam int unsigned AW    = 2;
  localparam int unsigned DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic         lrclk;
  logic [W-1:0] mic;
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;
  logic         tlast;
  logic         busy;
  logic         ovf;
`ifdef FRAMER_OVF_CNT_EN
  logic [15:0]  ovf_count;
`endif

  always #5 clk = ~clk;

  i2s_sample_framer #(
    .C_DATA_WIDTH (W),
    .FRAME_LEN    (FL),
    .FIFO_AW      (AW)
  ) dut (
    .CLK_12     (clk),
    .reset      (rst),
    .enable     (enable),
    .LRCLK_I    (lrclk),
    .mic_sample (mic),
    .m_tdata    (tdata),
    .m_tvalid   (tvalid),
    .m_tready   (tready),
    .m_tlast    (tlast),
    .busy       (busy),
    .ovf        (ovf)
`ifdef FRAMER_OVF_CNT_EN
    ,
    .ovf_count  (ovf_count)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: expected output stream plus frame/overflow bookkeeping.
  logic [W:0]   exp_q[$];
  int           occ;
  int           m_cnt;
  int           m_drops;
  bit           m_busy;
  bit           m_ovf;
  bit           lr_prev;
  bit           stall_prev;
  logic [W-1:0] tdata_prev;
  logic         tlast_prev;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    occ        = 0;
    m_cnt      = 0;
    m_drops    = 0;
    m_busy     = 0;
    m_ovf      = 0;
    stall_prev = 0;
  endtask

  task automatic model_event();
    bit last;
    if (enable || m_busy) begin
      if (occ < DEPTH) begin
        last = (m_cnt == FL - 1);
        exp_q.push_back({last, mic});
        m_cnt  = last ? 0 : m_cnt + 1;
        m_busy = enable || !last;
        occ++;
      end else begin
        m_drops++;
        m_ovf  = 1;
        m_busy = m_busy && (enable || m_cnt != 0);
      end
    end
  endtask

  // One clock: observe at the falling edge, then return just after the rising edge.
  task automatic tick();
    logic [W:0] e;
    @(negedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (stall_prev) begin
        check("hold_valid", {31'd0, tvalid}, 32'd1);
        check("hold_data", {8'd0, tdata}, {8'd0, tdata_prev});
        check("hold_last", {31'd0, tlast}, {31'd0, tlast_prev});
      end
      if (tvalid && tready) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          failures++;
          $error("FAIL unexpected_xfer observed=%0h expected=none", tdata);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("xfer_data", {8'd0, tdata}, {8'd0, e[W-1:0]});
          check("xfer_last", {31'd0, tlast}, {31'd0, e[W]});
          occ--;
        end
      end
      if (lrclk && !lr_prev) model_event();
      stall_prev = tvalid && !tready;
      tdata_prev = tdata;
      tlast_prev = tlast;
    end
    lr_prev = rst ? 1'b1 : lrclk;
    @(posedge clk);
    #1;
  endtask

  task automatic lr_event(input logic [W-1:0] s, input bit rnd_ready);
    mic   = s;
    lrclk = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (rnd_ready) tready = 1'($urandom_range(0, 1));
      tick();
    end
    lrclk = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (rnd_ready) tready = 1'($urandom_range(0, 1));
      tick();
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, {31'd0, m_busy});
    check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, m_ovf});
`ifdef FRAMER_OVF_CNT_EN
    check({tag, "_ovfcnt"}, {16'd0, ovf_count}, 32'(m_drops));
`endif
  endtask

  task automatic drain(input string tag);
    tready = 1'b1;
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
    repeat (3) tick();
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_valid_low"}, {31'd0, tvalid}, 32'd0);
  endtask

  task automatic finish_frame(input string tag);
    enable = 1'b0;
    for (int i = 0; i < 16 && m_busy; i++) lr_event(W'($urandom), 1'b0);
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst    = 1'b1;
    enable = 1'b0;
    lrclk  = 1'b0;
    tready = 1'b1;
    mic    = '0;
    lr_prev = 1'b1;
    model_reset();
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_tvalid", {31'd0, tvalid}, 32'd0);
    check("rst_tdata", {8'd0, tdata}, 32'd0);
    check("rst_tlast", {31'd0, tlast}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);

    // Two back-to-back frames with enable held.
    enable = 1'b1;
    for (int i = 1; i <= 8; i++) lr_event(W'(i), 1'b0);
    check_state("frames");
    check("frames_busy_run", {31'd0, busy}, 32'd1);

    // Enable dropped after sample 2: the frame still completes.
    lr_event(W'(9), 1'b0);
    lr_event(W'(10), 1'b0);
    enable = 1'b0;
    lr_event(W'(11), 1'b0);
    check("drain_busy", {31'd0, busy}, 32'd1);
    lr_event(W'(12), 1'b0);
    check("drain_done_idle", {31'd0, busy}, 32'd0);
    lr_event(W'(13), 1'b0);
    check_state("idle_no_cap");
    drain("closed");

    // Overflow with downstream stalled, then a write into a full FIFO during a read.
    tready = 1'b0;
    enable = 1'b1;
    for (int i = 1; i <= 6; i++) lr_event(W'(i), 1'b0);
    check("ovf_set", {31'd0, ovf}, 32'd1);
    check_state("ovf");
    tready = 1'b1;
    lr_event(W'(7), 1'b0);
    check_state("full_rw");
    finish_frame("ovf_tail");
    drain("ovf");

    // Reset mid-frame with LRCLK already high at release.
    enable = 1'b1;
    tready = 1'b0;
    lr_event(W'(31), 1'b0);
    lr_event(W'(32), 1'b0);
    check("pre_rst_valid", {31'd0, tvalid}, 32'd1);
    rst   = 1'b1;
    lrclk = 1'b1;
    mic   = W'(99);
    tick();
    check("mid_rst_tvalid", {31'd0, tvalid}, 32'd0);
    check("mid_rst_tdata", {8'd0, tdata}, 32'd0);
    check("mid_rst_tlast", {31'd0, tlast}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_ovf", {31'd0, ovf}, 32'd0);
    tick();
    rst = 1'b0;
    tready = 1'b1;
    repeat (4) tick();
    check("lr_high_no_cap_busy", {31'd0, busy}, 32'd0);
    check("lr_high_no_cap_valid", {31'd0, tvalid}, 32'd0);
    lrclk = 1'b0;
    tick();
    for (int i = 21; i <= 23; i++) lr_event(W'(i), 1'b0);
    enable = 1'b0;
    lr_event(W'(24), 1'b0);
    check_state("fresh_frame");
    drain("fresh");

    // Randomized enable, backpressure and data.
    for (int i = 0; i < 48; i++) begin
      enable = ($urandom_range(0, 9) < 7);
      lr_event(W'($urandom), 1'b1);
      check_state("rnd");
    end
    finish_frame("rnd_tail");
    drain("rnd");
    check_state("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
